sram_word_ctrl: RTL



---
 rtl/sram_word_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sram_word_ctrl.sv
`timescale 1ns/1ps
// Word-to-SRAM bridge: splits one CPU word access into WORD_W/SRAM_DW sequential
// 16-bit beats on an asynchronous SRAM, with programmable read/write/recovery timing.
module sram_word_ctrl #(
   parameter int unsigned WORD_W     = 32,
   parameter int unsigned SRAM_DW    = 16,
   parameter int unsigned SRAM_AW    = 18,
   parameter logic [31:0] BASE_ADDR  = 32'd1024,
   parameter int unsigned RD_WAIT    = 2,
   parameter int unsigned WR_PULSE   = 1,
   parameter int unsigned WR_RECOVER = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wrEn,
   input  logic                  rdEn,
   input  logic [31:0]           address,
   input  logic [WORD_W-1:0]     writeData,
   input  logic [WORD_W/8-1:0]   byteEn,
   output logic [WORD_W-1:0]     readData,
   output logic                  ready,
   output logic                  busy,
   inout  wire  [SRAM_DW-1:0]    SRAM_DQ,
   output logic [SRAM_AW-1:0]    SRAM_ADDR,
   output logic                  SRAM_WE_N,
   output logic                  SRAM_OE_N,
   output logic                  SRAM_CE_N,
   output logic                  SRAM_UB_N,
   output logic                  SRAM_LB_N
);

   localparam int unsigned BEATS = WORD_W / SRAM_DW;
   localparam int unsigned BI    = $clog2(BEATS);
   localparam int unsigned BB    = $clog2(WORD_W / 8);
   localparam int unsigned BIW   = (BI > 0) ? BI : 1;
   localparam int unsigned CW    = 16;

   localparam logic [BIW-1:0] BEAT_LAST = BIW'(BEATS - 1);
   localparam logic [CW-1:0]  RD_LAST   = CW'(RD_WAIT - 1);
   localparam logic [CW-1:0]  WR_LAST   = CW'(WR_PULSE - 1);
   localparam logic [CW-1:0]  REC_LAST  = CW'((WR_RECOVER > 0) ? WR_RECOVER - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR_BEAT,
      S_WR_RECOVER,
      S_RD_BEAT,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic [BIW-1:0]        beat_q, beat_d;
   logic [CW-1:0]         wait_q, wait_d;
   logic [SRAM_AW-1:0]    addr_base_q;
   logic [WORD_W-1:0]     wdata_q;
   logic [WORD_W/8-1:0]   be_q;
   logic [WORD_W-1:0]     rdata_q;

   logic [SRAM_DW-1:0]    beat_data;
   logic [1:0]            beat_be;
   logic                  dq_oe;

   // Request fields are latched every IDLE cycle, so the value at the leaving edge is kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         beat_q      <= '0;
         wait_q      <= '0;
         addr_base_q <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rdata_q     <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         wait_q  <= wait_d;
         if (state_q == S_IDLE) begin
            addr_base_q <= SRAM_AW'(((address - BASE_ADDR) >> BB) << BI);
            wdata_q     <= writeData;
            be_q        <= byteEn;
         end
         if (state_q == S_RD_BEAT && wait_q == RD_LAST) begin
            for (int unsigned i = 0; i < BEATS; i++) begin
               if (beat_q == BIW'(i)) rdata_q[i*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      wait_d  = wait_q;
      unique case (state_q)
         S_IDLE: begin
            beat_d = '0;
            wait_d = '0;
            if (wrEn)      state_d = S_WR_BEAT;
            else if (rdEn) state_d = S_RD_BEAT;
         end
         S_WR_BEAT: begin
            if (wait_q == WR_LAST) begin
               wait_d = '0;
               if (beat_q == BEAT_LAST) state_d = (WR_RECOVER == 0) ? S_DONE : S_WR_RECOVER;
               else                     beat_d  = beat_q + BIW'(1);
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         S_WR_RECOVER: begin
            if (wait_q == REC_LAST) begin
               wait_d  = '0;
               state_d = S_DONE;
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         S_RD_BEAT: begin
            if (wait_q == RD_LAST) begin
               wait_d = '0;
               if (beat_q == BEAT_LAST) state_d = S_DONE;
               else                     beat_d  = beat_q + BIW'(1);
            end else begin
               wait_d = wait_q + CW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      beat_data = '0;
      beat_be   = '0;
      for (int unsigned i = 0; i < BEATS; i++) begin
         if (beat_q == BIW'(i)) begin
            beat_data = wdata_q[i*SRAM_DW +: SRAM_DW];
            beat_be   = be_q[2*i +: 2];
         end
      end
   end

   // Pins decode from registered state only; request inputs never reach them.
   always_comb begin
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      SRAM_CE_N = 1'b1;
      SRAM_UB_N = 1'b1;
      SRAM_LB_N = 1'b1;
      SRAM_ADDR = '0;
      dq_oe     = 1'b0;
      ready     = 1'b0;
      busy      = (state_q != S_IDLE);
      unique case (state_q)
         S_WR_BEAT: begin
            SRAM_CE_N = 1'b0;
            SRAM_WE_N = 1'b0;
            SRAM_LB_N = ~beat_be[0];
            SRAM_UB_N = ~beat_be[1];
            SRAM_ADDR = addr_base_q | SRAM_AW'(beat_q);
            dq_oe     = 1'b1;
         end
         S_WR_RECOVER: begin
            SRAM_CE_N = 1'b0;
            SRAM_ADDR = addr_base_q | SRAM_AW'(beat_q);
         end
         S_RD_BEAT: begin
            SRAM_CE_N = 1'b0;
            SRAM_OE_N = 1'b0;
            SRAM_UB_N = 1'b0;
            SRAM_LB_N = 1'b0;
            SRAM_ADDR = addr_base_q | SRAM_AW'(beat_q);
         end
         S_DONE:  ready = 1'b1;
         default: ;
      endcase
   end

   assign SRAM_DQ  = dq_oe ? beat_data : 'z;
   assign readData = rdata_q;

endmodule
